// File: rtl/sc_alu_cc.sv
// Multi-cycle integer execute unit with N/Z/V/C generation and status-register write port.
// Latency: 2 cycles accept-to-done for ALU ops, 2 + shamt cycles for shifts.
// Optional ADDX/SUBX opcodes (1000/1001) when SC_ALUCC_ADDX_EN is defined.
module sc_alu_cc #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  SC_AluCc_CLOCK_50,
  input  logic                  SC_AluCc_RESET_InHigh,
  input  logic                  SC_AluCc_start,
  input  logic [3:0]            SC_AluCc_op,
  input  logic [DATA_WIDTH-1:0] SC_AluCc_a,
  input  logic [DATA_WIDTH-1:0] SC_AluCc_b,
  input  logic                  SC_AluCc_set_cc,
  input  logic                  SC_AluCc_carry_in,
  output logic                  SC_AluCc_busy,
  output logic                  SC_AluCc_done,
  output logic [DATA_WIDTH-1:0] SC_AluCc_result,
  output logic                  SC_AluCc_Psr_Write_InLow,
  output logic                  SC_AluCc_negativo,
  output logic                  SC_AluCc_cero,
  output logic                  SC_AluCc_overflow,
  output logic                  SC_AluCc_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, WRITE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_ADDX = 4'b1000;
  localparam logic [3:0] OP_SUBX = 4'b1001;

  localparam int MSB = DATA_WIDTH - 1;

  state_t                 state, state_nxt;
  logic [3:0]             op_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q;
  logic                   set_cc_q;
  logic [DATA_WIDTH-1:0]  sh_q, sh_nxt;
  logic                   sh_out;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   xcin;
  logic [DATA_WIDTH:0]    sum, diff;
  logic [DATA_WIDTH-1:0]  alu_res, fin_res;
  logic                   alu_c, alu_v, fin_c, fin_v;

  assign shamt    = b_q[SHAMT_WIDTH-1:0];
  assign is_shift = op_q inside {OP_SLL, OP_SRL, OP_SRA};

`ifdef SC_ALUCC_ADDX_EN
  logic cin_q;
  // Extended-precision ops fold the latched status carry into the add/sub chain.
  assign xcin = (op_q == OP_ADDX || op_q == OP_SUBX) & cin_q;
`else
  logic unused_cin;
  assign unused_cin = SC_AluCc_carry_in;
  assign xcin       = 1'b0;
`endif

  // One extra bit catches carry-out of the add and borrow of the subtract.
  assign sum  = {1'b0, a_q} + {1'b0, b_q} + {{DATA_WIDTH{1'b0}}, xcin};
  assign diff = {1'b0, a_q} - {1'b0, b_q} - {{DATA_WIDTH{1'b0}}, xcin};

  // Single-cycle ALU result and V/C; shifts and unknown codes pass A with V=C=0.
  always_comb begin
    alu_res = a_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
`ifdef SC_ALUCC_ADDX_EN
      OP_ADD, OP_ADDX: begin
`else
      OP_ADD: begin
`endif
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_WIDTH];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
`ifdef SC_ALUCC_ADDX_EN
      OP_SUB, OP_SUBX: begin
`else
      OP_SUB: begin
`endif
        alu_res = diff[MSB:0];
        alu_c   = diff[DATA_WIDTH];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = a_q;
    endcase
  end

  // One-bit shift step and the bit it pushes out.
  always_comb begin
    sh_nxt = sh_q;
    sh_out = 1'b0;
    case (op_q)
      OP_SLL: begin
        sh_nxt = {sh_q[MSB-1:0], 1'b0};
        sh_out = sh_q[MSB];
      end
      OP_SRL: begin
        sh_nxt = {1'b0, sh_q[MSB:1]};
        sh_out = sh_q[0];
      end
      default: begin
        sh_nxt = {sh_q[MSB], sh_q[MSB:1]};
        sh_out = sh_q[0];
      end
    endcase
  end

  // Next state plus the value to be published when entering WRITE.
  always_comb begin
    state_nxt = state;
    fin_res   = alu_res;
    fin_c     = alu_c;
    fin_v     = alu_v;
    case (state)
      IDLE:  if (SC_AluCc_start) state_nxt = EXEC;
      // A zero-count shift publishes A with C=0, which the ALU default already gives.
      EXEC:  state_nxt = (is_shift && shamt != '0) ? SHIFT : WRITE;
      SHIFT: begin
        fin_res = sh_nxt;
        fin_c   = sh_out;
        fin_v   = 1'b0;
        if (cnt_q == SHAMT_WIDTH'(1)) state_nxt = WRITE;
      end
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge SC_AluCc_CLOCK_50 or posedge SC_AluCc_RESET_InHigh) begin
    if (SC_AluCc_RESET_InHigh) state <= IDLE;
    else                       state <= state_nxt;
  end

  // Operand capture at accept and the serial shifter datapath.
  always_ff @(posedge SC_AluCc_CLOCK_50 or posedge SC_AluCc_RESET_InHigh) begin
    if (SC_AluCc_RESET_InHigh) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      set_cc_q <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
`ifdef SC_ALUCC_ADDX_EN
      cin_q    <= 1'b0;
`endif
    end else begin
      if (state == IDLE && SC_AluCc_start) begin
        op_q     <= SC_AluCc_op;
        a_q      <= SC_AluCc_a;
        b_q      <= SC_AluCc_b;
        set_cc_q <= SC_AluCc_set_cc;
`ifdef SC_ALUCC_ADDX_EN
        cin_q    <= SC_AluCc_carry_in;
`endif
      end
      if (state == EXEC) begin
        sh_q  <= a_q;
        cnt_q <= shamt;
      end
      if (state == SHIFT) begin
        sh_q  <= sh_nxt;
        cnt_q <= cnt_q - SHAMT_WIDTH'(1);
      end
    end
  end

  // Result and flags load on entry to WRITE so they are valid with done, then hold.
  always_ff @(posedge SC_AluCc_CLOCK_50 or posedge SC_AluCc_RESET_InHigh) begin
    if (SC_AluCc_RESET_InHigh) begin
      SC_AluCc_result   <= '0;
      SC_AluCc_negativo <= 1'b0;
      SC_AluCc_cero     <= 1'b0;
      SC_AluCc_overflow <= 1'b0;
      SC_AluCc_carry    <= 1'b0;
    end else if (state != WRITE && state_nxt == WRITE) begin
      SC_AluCc_result   <= fin_res;
      SC_AluCc_negativo <= fin_res[MSB];
      SC_AluCc_cero     <= (fin_res == '0);
      SC_AluCc_overflow <= fin_v;
      SC_AluCc_carry    <= fin_c;
    end
  end

  assign SC_AluCc_busy            = (state != IDLE);
  assign SC_AluCc_done            = (state == WRITE);
  assign SC_AluCc_Psr_Write_InLow = !(state == WRITE && set_cc_q);

endmodule

// File: tb/tb_sc_alu_cc.sv
// Directed self-checking bench for sc_alu_cc with an expected-result scoreboard.
// Checks latency, busy window, strobe width, flags, held outputs and async reset abort.
// Build with SC_ALUCC_ADDX_EN defined to exercise the ADDX expectation variant.
module tb_sc_alu_cc;

    typedef struct {
        logic [31:0] res;
        logic        n, z, v, c;
        int          lat;
        int          strb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic        set_cc = 1'b0, carry_in = 1'b0;
    logic        busy, done, psr_n, neg, zero, ovf, cy;
    logic [31:0] result;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    sc_alu_cc #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .SC_AluCc_CLOCK_50        (clk),
        .SC_AluCc_RESET_InHigh    (rst),
        .SC_AluCc_start           (start),
        .SC_AluCc_op              (op),
        .SC_AluCc_a               (a),
        .SC_AluCc_b               (b),
        .SC_AluCc_set_cc          (set_cc),
        .SC_AluCc_carry_in        (carry_in),
        .SC_AluCc_busy            (busy),
        .SC_AluCc_done            (done),
        .SC_AluCc_result          (result),
        .SC_AluCc_Psr_Write_InLow (psr_n),
        .SC_AluCc_negativo        (neg),
        .SC_AluCc_cero            (zero),
        .SC_AluCc_overflow        (ovf),
        .SC_AluCc_carry           (cy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s", tag);
        end
    endtask

    // Drive one operation, push its expectation, then compare when done appears.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] oa, input logic [31:0] ob,
                         input logic sc, input logic ci, input logic pulse,
                         input logic [31:0] er, input logic en, input logic ez, input logic ev, input logic ec,
                         input int elat);
        exp_t e, got_e;
        int   k, strb, bcnt, extra;
        bit   got;
        @(negedge clk);
        op = o; a = oa; b = ob; set_cc = sc; carry_in = ci; start = 1'b1;
        e.res = er; e.n = en; e.z = ez; e.v = ev; e.c = ec; e.lat = elat; e.strb = sc ? 1 : 0;
        sbq.push_back(e);
        @(negedge clk);
        // Scramble inputs after accept: the DUT must work from its latched copies.
        start = 1'b0; op = 4'hF; a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; set_cc = ~sc; carry_in = ~ci;
        k = 1; strb = 0; bcnt = 0; got = 0;
        while (!got && k <= 40) begin
            start = (pulse && k == 1) ? 1'b1 : 1'b0;
            if (busy) bcnt++;
            if (!psr_n) strb++;
            if (done) got = 1;
            else begin
                k++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, got === 1'b1);
        if (got && sbq.size() != 0) begin
            got_e = sbq.pop_front();
            chk({tag, "_result"}, result === got_e.res);
            chk({tag, "_N"}, neg === got_e.n);
            chk({tag, "_Z"}, zero === got_e.z);
            chk({tag, "_V"}, ovf === got_e.v);
            chk({tag, "_C"}, cy === got_e.c);
            chk({tag, "_latency"}, k == got_e.lat);
            chk({tag, "_busy_cycles"}, bcnt == got_e.lat);
            chk({tag, "_strobe_cycles"}, strb == got_e.strb);
            @(negedge clk);
            chk({tag, "_post_done"}, done === 1'b0);
            chk({tag, "_post_busy"}, busy === 1'b0);
            chk({tag, "_post_strobe"}, psr_n === 1'b1);
            chk({tag, "_held_result"}, result === got_e.res);
            chk({tag, "_held_C"}, cy === got_e.c);
            extra = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk({tag, "_extra_done"}, extra == 0);
        end
    endtask

    initial begin
        int strb, dn;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy === 1'b0);
        chk("reset_done", done === 1'b0);
        chk("reset_result", result === 32'h0);
        chk("reset_strobe", psr_n === 1'b1);
        chk("reset_flags", {neg, zero, ovf, cy} === 4'b0000);
        rst = 1'b0;

        //    tag         op     A             B             sc ci pl result        N  Z  V  C  lat
        do_op("add_ovf",  4'h0, 32'h7FFFFFFF, 32'h00000001, 1, 0, 0, 32'h80000000, 1, 0, 1, 0, 2);
        do_op("sub_eq",   4'h1, 32'h00000005, 32'h00000005, 1, 0, 0, 32'h00000000, 0, 1, 0, 0, 2);
        do_op("sub_brw",  4'h1, 32'h00000003, 32'h00000005, 1, 0, 0, 32'hFFFFFFFE, 1, 0, 0, 1, 2);
        do_op("sra4",     4'h7, 32'h80000001, 32'h00000004, 1, 0, 0, 32'hF8000000, 1, 0, 0, 0, 6);
        do_op("sra0",     4'h7, 32'h80000001, 32'h00000000, 1, 0, 0, 32'h80000001, 1, 0, 0, 0, 2);
        do_op("srl2",     4'h6, 32'h0000000F, 32'h00000002, 1, 0, 0, 32'h00000003, 0, 0, 0, 1, 4);
        do_op("sll1",     4'h5, 32'hC0000000, 32'h00000001, 1, 0, 0, 32'h80000000, 1, 0, 0, 1, 3);
        do_op("or",       4'h3, 32'h00001200, 32'h00000034, 1, 0, 0, 32'h00001234, 0, 0, 0, 0, 2);
        do_op("xor",      4'h4, 32'hFFFF0000, 32'hFF00FF00, 1, 0, 0, 32'h00FFFF00, 0, 0, 0, 0, 2);
        do_op("other_op", 4'hF, 32'h8000ABCD, 32'h12345678, 1, 0, 0, 32'h8000ABCD, 1, 0, 0, 0, 2);
        do_op("and_nocc", 4'h2, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 0, 1, 32'h00000000, 0, 1, 0, 0, 2);

        // Abort a long SLL mid-shift with an asynchronous reset.
        @(negedge clk);
        op = 4'h5; a = 32'h00000001; b = 32'd20; set_cc = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        strb = 0; dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (!psr_n) strb++;
            if (done) dn++;
        end
        chk("rst_mid_busy_before", busy === 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy === 1'b0);
        chk("rst_mid_done", done === 1'b0);
        chk("rst_mid_result", result === 32'h0);
        chk("rst_mid_strobe", psr_n === 1'b1);
        chk("rst_mid_flags", {neg, zero, ovf, cy} === 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (!psr_n) strb++;
            if (done) dn++;
        end
        chk("rst_mid_no_strobe", strb == 0);
        chk("rst_mid_no_done", dn == 0);
        chk("rst_mid_idle", busy === 1'b0);

        do_op("add_after_rst", 4'h0, 32'h00000001, 32'h00000002, 1, 0, 0, 32'h00000003, 0, 0, 0, 0, 2);
`ifdef SC_ALUCC_ADDX_EN
        do_op("addx", 4'h8, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 32'h00000000, 0, 1, 0, 1, 2);
`else
        do_op("addx_off", 4'h8, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
